// File: rtl/or1200_checker_resp_if.sv
// or1200_checker_resp_if: checker inputs, except-unit handshake and alarm status.
// The DUT takes the slave side; the environment drives the master side.
interface or1200_checker_resp_if #(
  parameter int CNT_W = 8
);
  logic             chk_en;
  logic             sr_ok;
  logic             pipeline_ok;
  logic             mmus_ok;
  logic [2:0]       secure_supv;
  logic             except_ack;
  logic             except_req;
  logic             halt;
  logic [2:0]       alarm_cause;
  logic             alarm_supv;
  logic [CNT_W-1:0] alarm_cnt;
  logic [CNT_W-1:0] glitch_cnt;

  modport master (
    output chk_en, sr_ok, pipeline_ok, mmus_ok,
    output secure_supv, except_ack,
    input  except_req, halt, alarm_cause,
    input  alarm_supv, alarm_cnt, glitch_cnt
  );

  modport slave (
    input  chk_en, sr_ok, pipeline_ok, mmus_ok,
    input  secure_supv, except_ack,
    output except_req, halt, alarm_cause,
    output alarm_supv, alarm_cnt, glitch_cnt
  );
endinterface

// File: rtl/or1200_checker_resp.sv
// or1200_checker_resp: filters checker violations, raises except_req, locks core.
// Option OR1200_CHECKER_RESP_SUPV_MASK_EN masks mmus_ok faults in supervisor.
module or1200_checker_resp #(
  parameter int FILTER_CYCLES = 2,
  parameter int MAX_ALARMS    = 4,
  parameter int CNT_W         = 8
) (
  input logic                  clk,
  input logic                  rst,
  or1200_checker_resp_if.slave bus
);
  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    PENDING = 2'd1,
    ALARM   = 2'd2,
    LOCK    = 2'd3
  } state_t;

  localparam logic [3:0]       FCYC = 4'(FILTER_CYCLES);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] AMAX = CNT_W'(MAX_ALARMS);

  state_t           state_q;
  state_t           state_d;
  logic [3:0]       fcnt_q;
  logic [3:0]       fcnt_d;
  logic [2:0]       acc_q;
  logic [2:0]       acc_d;
  logic             sr_q;
  logic             pipe_q;
  logic             mmu_q;
  logic [2:0]       ss_q;
  logic [2:0]       cause_q;
  logic             supv_lat_q;
  logic [CNT_W-1:0] acnt_q;
  logic [CNT_W-1:0] gcnt_q;
  logic             supv;
  logic             mmu_bad;
  logic [2:0]       fault;
  logic             viol;
  logic             fire;
  logic             drop;

  assign supv = ~^ss_q;

`ifdef OR1200_CHECKER_RESP_SUPV_MASK_EN
  assign mmu_bad = ~mmu_q & ~supv;
`else
  assign mmu_bad = ~mmu_q;
`endif

  assign fault = {mmu_bad, ~pipe_q, ~sr_q};
  assign viol  = bus.chk_en & (|fault);

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    acc_d   = acc_q;
    fire    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      ARMED: begin
        if (viol) begin
          acc_d = fault;
          if (FCYC == 4'd1) begin
            fire    = 1'b1;
            state_d = ALARM;
            fcnt_d  = 4'd0;
          end else begin
            state_d = PENDING;
            fcnt_d  = 4'd1;
          end
        end
      end
      PENDING: begin
        if (!bus.chk_en) begin
          state_d = ARMED;
          fcnt_d  = 4'd0;
        end else if (viol) begin
          acc_d = acc_q | fault;
          if (fcnt_q + 4'd1 == FCYC) begin
            fire    = 1'b1;
            state_d = ALARM;
            fcnt_d  = 4'd0;
          end else begin
            fcnt_d = fcnt_q + 4'd1;
          end
        end else begin
          drop    = 1'b1;
          state_d = ARMED;
          fcnt_d  = 4'd0;
        end
      end
      ALARM: begin
        if (bus.except_ack)
          state_d = (acnt_q >= AMAX) ? LOCK : ARMED;
      end
      LOCK: state_d = LOCK;
      default: state_d = ARMED;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ARMED;
      fcnt_q     <= 4'd0;
      acc_q      <= 3'd0;
      sr_q       <= 1'b1;
      pipe_q     <= 1'b1;
      mmu_q      <= 1'b1;
      ss_q       <= 3'd0;
      cause_q    <= 3'd0;
      supv_lat_q <= 1'b0;
      acnt_q     <= '0;
      gcnt_q     <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      acc_q   <= acc_d;
      sr_q    <= bus.sr_ok;
      pipe_q  <= bus.pipeline_ok;
      mmu_q   <= bus.mmus_ok;
      ss_q    <= bus.secure_supv;
      if (fire) begin
        cause_q    <= acc_d;
        supv_lat_q <= supv;
        if (acnt_q != CMAX)
          acnt_q <= acnt_q + 1'b1;
      end
      if (drop && gcnt_q != CMAX)
        gcnt_q <= gcnt_q + 1'b1;
    end
  end

  assign bus.except_req  = (state_q == ALARM);
  assign bus.halt        = (state_q == LOCK);
  assign bus.alarm_cause = cause_q;
  assign bus.alarm_supv  = supv_lat_q;
  assign bus.alarm_cnt   = acnt_q;
  assign bus.glitch_cnt  = gcnt_q;
endmodule
